// File: rtl/codemem_loader_pkg.sv
// Shared types and sizing for the code memory and its run-time loader.
// Optional checksum build: CODEMEM_LOADER_CHECKSUM_EN adds the GET_CK state.
package codemem_loader_pkg;

  localparam int CODE_ADDR_W = 6;
  localparam int INSTR_W     = 16;
  localparam int USER_BASE   = 32;
  localparam int USER_WORDS  = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_HI = 3'd1,
    GET_LO = 3'd2,
    WRITE  = 3'd3,
    FINISH = 3'd4
`ifdef CODEMEM_LOADER_CHECKSUM_EN
    , GET_CK = 3'd5
`endif
  } state_t;

  // A zero length requests the whole user region.
  function automatic logic [CODE_ADDR_W:0] effective_len(input logic [CODE_ADDR_W-1:0] len,
                                                         input int region_words);
    return (len == '0) ? (CODE_ADDR_W+1)'(region_words) : {1'b0, len};
  endfunction

endpackage

// File: rtl/codemem_loader_byte_pair_assembler.sv
// Captures hi/lo stream bytes into one instruction word and, with
// CODEMEM_LOADER_CHECKSUM_EN, keeps the running 8-bit sum of data bytes.
module byte_pair_assembler
  import codemem_loader_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               hi_en,
  input  logic               lo_en,
  input  logic [7:0]         byte_data,
`ifdef CODEMEM_LOADER_CHECKSUM_EN
  output logic               ck_mismatch,
`endif
  output logic               word_ready,
  output logic [INSTR_W-1:0] word_data
);

  logic [7:0] hi_q;
  logic [7:0] lo_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_q       <= 8'h00;
      lo_q       <= 8'h00;
      word_ready <= 1'b0;
    end else begin
      if (hi_en) hi_q <= byte_data;
      if (lo_en) lo_q <= byte_data;
      word_ready <= lo_en;
    end
  end

  assign word_data = {hi_q, lo_q};

`ifdef CODEMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sum_with_byte;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)              sum_q <= 8'h00;
    else if (clear)         sum_q <= 8'h00;
    else if (hi_en | lo_en) sum_q <= sum_q + byte_data;
  end

  // The checksum byte is valid when it brings the modular sum back to zero.
  assign sum_with_byte = sum_q + byte_data;
  assign ck_mismatch   = (sum_with_byte != 8'h00);
`else
  logic unused_clear;
  assign unused_clear = clear;
`endif

endmodule

// File: rtl/codemem_loader.sv
// Byte-stream loader for the user region of the code memory; halts the CPU
// while loading. CODEMEM_LOADER_CHECKSUM_EN appends a checksum byte per session.
module codemem_loader
  import codemem_loader_pkg::*;
#(
  parameter int BASE_ADDR    = USER_BASE,
  parameter int REGION_WORDS = USER_WORDS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CODE_ADDR_W-1:0] len,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  output logic                   mem_we,
  output logic [CODE_ADDR_W-1:0] mem_waddr,
  output logic [INSTR_W-1:0]     mem_wdata,
  output logic                   cpu_halt,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output state_t                 dbg_state
);

  // Stream handshake: a byte moves on a rising edge where byte_valid and
  // byte_ready are both high; byte_ready depends only on state, never on byte_valid.

  state_t                 state, state_next;
  logic [CODE_ADDR_W-1:0] addr;
  logic [CODE_ADDR_W:0]   count;
  logic [CODE_ADDR_W:0]   eff_len;
  logic [CODE_ADDR_W:0]   start_len;
  logic                   start_bad;
  logic                   start_acc;
  logic                   last_word;
  logic                   hi_en, lo_en;
  logic                   word_ready;
`ifdef CODEMEM_LOADER_CHECKSUM_EN
  logic                   ck_mismatch;
`endif

  assign start_len = effective_len(len, REGION_WORDS);
  assign start_bad = start_len > (CODE_ADDR_W+1)'(REGION_WORDS);
  assign start_acc = (state == IDLE) && start;
  assign last_word = (count + 1'b1) == eff_len;
  assign hi_en     = (state == GET_HI) && byte_valid;
  assign lo_en     = (state == GET_LO) && byte_valid;

  byte_pair_assembler u_assembler (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_acc),
    .hi_en      (hi_en),
    .lo_en      (lo_en),
    .byte_data  (byte_data),
`ifdef CODEMEM_LOADER_CHECKSUM_EN
    .ck_mismatch(ck_mismatch),
`endif
    .word_ready (word_ready),
    .word_data  (mem_wdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start && !start_bad) state_next = GET_HI;
      GET_HI: if (byte_valid) state_next = GET_LO;
      GET_LO: if (byte_valid) state_next = WRITE;
      WRITE: begin
        if (!last_word)     state_next = GET_HI;
`ifdef CODEMEM_LOADER_CHECKSUM_EN
        else                state_next = GET_CK;
      end
      GET_CK: if (byte_valid) state_next = FINISH;
`else
        else                state_next = FINISH;
      end
`endif
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = (state == GET_HI) || (state == GET_LO);
`ifdef CODEMEM_LOADER_CHECKSUM_EN
    if (state == GET_CK) byte_ready = 1'b1;
`endif
    mem_we    = (state == WRITE) && word_ready;
    busy      = (state != IDLE);
    cpu_halt  = busy;
    done      = (state == FINISH) && !error;
    mem_waddr = addr;
    dbg_state = state;
  end

  // The address is held on the final write so it never leaves the region.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr    <= CODE_ADDR_W'(BASE_ADDR);
      count   <= '0;
      eff_len <= '0;
      error   <= 1'b0;
    end else begin
      if (start_acc) begin
        addr    <= CODE_ADDR_W'(BASE_ADDR);
        count   <= '0;
        eff_len <= start_len;
        error   <= start_bad;
      end
      if (state == WRITE) begin
        count <= count + 1'b1;
        if (!last_word) addr <= addr + 1'b1;
      end
`ifdef CODEMEM_LOADER_CHECKSUM_EN
      if ((state == GET_CK) && byte_valid && ck_mismatch) error <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_codemem_loader.sv
// Self-checking bench for codemem_loader; covers the checksum build when
// CODEMEM_LOADER_CHECKSUM_EN is defined.
module tb_codemem_loader;
  import codemem_loader_pkg::*;

  localparam int BASE  = 32;
  localparam int WORDS = 32;
`ifdef CODEMEM_LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic        clock;
  logic        reset;
  logic        start;
  logic [5:0]  len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic        cpu_halt;
  logic        busy;
  logic        done;
  logic        error;
  state_t      dbg_state;

  codemem_loader dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .cpu_halt  (cpu_halt),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  logic [21:0] exp_q[$];
  int n_cmp, n_fail;
  int n_writes, n_done, n_halt, done_at_halt;
  logic [5:0] last_waddr, min_waddr;
  logic [7:0] run_sum;

  always @(negedge clock) begin
    logic [21:0] exp;
    if (cpu_halt === 1'b1) n_halt++;
    if (done === 1'b1) begin
      n_done++;
      done_at_halt = n_halt;
    end
    if (mem_we === 1'b1) begin
      n_writes++;
      last_waddr = mem_waddr;
      if (mem_waddr < min_waddr) min_waddr = mem_waddr;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: got addr=%0d data=%h, none expected", mem_waddr, mem_wdata);
      end else begin
        exp = exp_q.pop_front();
        if ({mem_waddr, mem_wdata} !== exp || byte_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL write_data: got addr=%0d data=%h ready=%b, expected addr=%0d data=%h ready=0",
                   mem_waddr, mem_wdata, byte_ready, exp[21:16], exp[15:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    n_writes = 0; n_done = 0; n_halt = 0; done_at_halt = 0;
    last_waddr = 6'd0; min_waddr = 6'd63; run_sum = 8'h00;
  endtask

  task automatic do_start(input logic [5:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clock);
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) begin
      n_cmp++; n_fail++;
      $display("FAIL byte_timeout: byte_ready=%b, expected 1 within 50 cycles", byte_ready);
    end
    @(negedge clock);
    run_sum = run_sum + b;
  endtask

  task automatic push_word(input int idx, input logic [7:0] hi, input logic [7:0] lo);
    logic [5:0] a;
    a = 6'(BASE + idx);
    exp_q.push_back({a, hi, lo});
  endtask

  task automatic send_checksum(input logic [7:0] delta);
    logic [7:0] ck;
    ck = 8'h00 - run_sum + delta;
    if (CK != 0) send_byte(ck, 0);
  endtask

  task automatic wait_idle();
    int t;
    byte_valid = 1'b0;
    t = 0;
    while (busy !== 1'b0 && t < 500) begin
      @(negedge clock);
      t++;
    end
    if (t >= 500) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout: busy=%b, expected 0 within 500 cycles", busy);
    end
    repeat (2) @(negedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; len = 6'd0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({byte_ready, mem_we, mem_waddr, mem_wdata, cpu_halt, busy, done, error} !==
        {1'b0, 1'b0, 6'd32, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got ready=%b we=%b addr=%0d data=%h halt=%b busy=%b done=%b err=%b, expected 0 0 32 0000 0 0 0 0",
               byte_ready, mem_we, mem_waddr, mem_wdata, cpu_halt, busy, done, error);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_two_words();
    clear_stats();
    push_word(0, 8'h12, 8'h34);
    push_word(1, 8'h56, 8'h78);
    do_start(6'd2);
    n_cmp++;
    if (cpu_halt !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_rise: got halt=%b busy=%b, expected 1 1", cpu_halt, busy);
    end
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'h56, 0); send_byte(8'h78, 0);
    send_checksum(8'h00);
    wait_idle();
    n_cmp++;
    if (n_writes != 2 || n_done != 1) begin
      n_fail++;
      $display("FAIL two_words_counts: got writes=%0d done=%0d, expected 2 1", n_writes, n_done);
    end
    n_cmp++;
    if (n_halt != 7 + CK || done_at_halt != 7 + CK) begin
      n_fail++;
      $display("FAIL two_words_timing: got halt_cycles=%0d done_at=%0d, expected %0d %0d",
               n_halt, done_at_halt, 7 + CK, 7 + CK);
    end
  endtask

  task automatic run_session(input logic [5:0] l, input int max_gap, input logic [7:0] ck_delta);
    int eff;
    logic [7:0] hi, lo;
    clear_stats();
    eff = (l == 6'd0) ? WORDS : int'(l);
    do_start(l);
    for (int i = 0; i < eff; i++) begin
      hi = 8'($urandom);
      lo = 8'($urandom);
      push_word(i, hi, lo);
      send_byte(hi, $urandom_range(0, max_gap));
      send_byte(lo, $urandom_range(0, max_gap));
    end
    send_checksum(ck_delta);
    wait_idle();
  endtask

  task automatic test_full_region();
    run_session(6'd0, 0, 8'h00);
    n_cmp++;
    if (n_writes != WORDS || last_waddr != 6'd63 || min_waddr != 6'd32) begin
      n_fail++;
      $display("FAIL full_region: got writes=%0d last=%0d min=%0d, expected 32 63 32",
               n_writes, last_waddr, min_waddr);
    end
    n_cmp++;
    if (n_done != 1 || n_halt != 3 * WORDS + 1 + CK || error !== 1'b0) begin
      n_fail++;
      $display("FAIL full_region_done: got done=%0d halt=%0d err=%b, expected 1 %0d 0",
               n_done, n_halt, error, 3 * WORDS + 1 + CK);
    end
  endtask

  task automatic test_overlength();
    clear_stats();
    do_start(6'd40);
    repeat (4) @(negedge clock);
    n_cmp++;
    if (error !== 1'b1 || busy !== 1'b0 || n_halt != 0 || n_writes != 0) begin
      n_fail++;
      $display("FAIL overlength: got err=%b busy=%b halt=%0d writes=%0d, expected 1 0 0 0",
               error, busy, n_halt, n_writes);
    end
    push_word(0, 8'hA5, 8'h5A);
    do_start(6'd1);
    n_cmp++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL error_clear: got err=%b, expected 0", error);
    end
    send_byte(8'hA5, 0); send_byte(8'h5A, 0);
    send_checksum(8'h00);
    wait_idle();
    n_cmp++;
    if (n_writes != 1 || n_done != 1) begin
      n_fail++;
      $display("FAIL after_error_session: got writes=%0d done=%0d, expected 1 1", n_writes, n_done);
    end
  endtask

  task automatic test_stall();
    clear_stats();
    push_word(0, 8'hC3, 8'h3C);
    do_start(6'd1);
    send_byte(8'hC3, 0);
    byte_valid = 1'b0;
    repeat (10) @(negedge clock);
    n_cmp++;
    if (dbg_state !== GET_LO || byte_ready !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_hold: got state=%0d ready=%b we=%b busy=%b, expected GET_LO 1 0 1",
               dbg_state, byte_ready, mem_we, busy);
    end
    send_byte(8'h3C, 0);
    n_cmp++;
    if (mem_we !== 1'b1 || mem_waddr !== 6'd32 || mem_wdata !== 16'hC33C) begin
      n_fail++;
      $display("FAIL stall_write: got we=%b addr=%0d data=%h, expected 1 32 c33c",
               mem_we, mem_waddr, mem_wdata);
    end
    send_checksum(8'h00);
    wait_idle();
    n_cmp++;
    if (n_writes != 1 || n_done != 1 || n_halt != 14 + CK) begin
      n_fail++;
      $display("FAIL stall_counts: got writes=%0d done=%0d halt=%0d, expected 1 1 %0d",
               n_writes, n_done, n_halt, 14 + CK);
    end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    push_word(0, 8'h11, 8'h22);
    do_start(6'd2);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    reset = 1'b1;
    byte_valid = 1'b0;
    #1;
    n_cmp++;
    if ({byte_ready, mem_we, mem_waddr, mem_wdata, cpu_halt, busy, done, error} !==
        {1'b0, 1'b0, 6'd32, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_values: got ready=%b we=%b addr=%0d data=%h halt=%b busy=%b done=%b err=%b, expected 0 0 32 0000 0 0 0 0",
               byte_ready, mem_we, mem_waddr, mem_wdata, cpu_halt, busy, done, error);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    n_cmp++;
    if (n_writes != 1 || n_done != 0 || exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_counts: got writes=%0d done=%0d pending=%0d busy=%b, expected 1 0 0 0",
               n_writes, n_done, exp_q.size(), busy);
    end
  endtask

  task automatic test_random();
    logic [5:0] l;
    for (int s = 0; s < 6; s++) begin
      l = 6'($urandom_range(1, 6));
      run_session(l, 2, 8'h00);
      n_cmp++;
      if (n_writes != int'(l) || n_done != 1 || error !== 1'b0) begin
        n_fail++;
        $display("FAIL random_session_%0d: got writes=%0d done=%0d err=%b, expected %0d 1 0",
                 s, n_writes, n_done, error, l);
      end
    end
  endtask

`ifdef CODEMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_stats();
    push_word(0, 8'h01, 8'h02);
    do_start(6'd1);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'hFD, 0);
    wait_idle();
    n_cmp++;
    if (n_done != 1 || error !== 1'b0 || n_writes != 1) begin
      n_fail++;
      $display("FAIL checksum_good: got done=%0d err=%b writes=%0d, expected 1 0 1", n_done, error, n_writes);
    end
    clear_stats();
    push_word(0, 8'h01, 8'h02);
    do_start(6'd1);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'hFE, 0);
    wait_idle();
    n_cmp++;
    if (n_done != 0 || error !== 1'b1 || n_writes != 1) begin
      n_fail++;
      $display("FAIL checksum_bad: got done=%0d err=%b writes=%0d, expected 0 1 1", n_done, error, n_writes);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_fail = 0;
    clear_stats();
    test_reset();
    test_two_words();
    test_full_region();
    test_overlength();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef CODEMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_writes: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
